// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the ctrl_seq multi-cycle controller: FSM states, ALU ops,
// writeback/ALU/PC/memory selects, RV32I major opcodes and immediate formats.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] RD_PC4 = 2'd2;
    localparam logic [1:0] RD_IMM = 2'd3;

    localparam logic ALU1_PC     = 1'b0;
    localparam logic ALU1_RS     = 1'b1;
    localparam logic ALU2_RS     = 1'b0;
    localparam logic ALU2_IMM    = 1'b1;
    localparam logic PC_SEL_PC4  = 1'b0;
    localparam logic PC_SEL_ALU  = 1'b1;
    localparam logic MEM_SEL_PC  = 1'b0;
    localparam logic MEM_SEL_ALU = 1'b1;

    localparam logic [2:0] IMM_I       = 3'd0;
    localparam logic [2:0] IMM_S       = 3'd1;
    localparam logic [2:0] IMM_B       = 3'd2;
    localparam logic [2:0] IMM_U       = 3'd3;
    localparam logic [2:0] IMM_J       = 3'd4;
    localparam logic [2:0] IMM_DEFAULT = 3'd7;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    function automatic logic is_legal(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [4:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// Combinational ALU-operation decode from the latched opcode, func3 and func7[5].
module ctrl_alu_dec
    import ctrl_seq_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (func3)
                3'b000:  alu_op = (opcode == OPC_OP && func7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = func7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// RV32I multi-cycle sequencing controller (FETCH/DECODE/EXEC/MEM/WB).
// Define CTRL_TIMEOUT_EN to trap when mem_ready stays low for MEM_TIMEOUT cycles.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             b,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             we,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             pc_sel,
    output logic [2:0]       imm_type,
    output logic             alu1_sel,
    output logic             alu2_sel,
    output logic [3:0]       alu_op,
    output logic [1:0]       rd_sel,
    output logic             reg_wr,
    output logic             trap,
    output logic [RET_W-1:0] retired
);

    state_t           state_reg, state_next;
    logic [4:0]       opcode_reg;
    logic [2:0]       func3_reg;
    logic             func7_5_reg;
    logic [RET_W-1:0] retired_reg;
    logic             retire;
    logic             timeout;
    logic [3:0]       dec_alu_op;
    logic             unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};
    assign retired      = retired_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            opcode_reg  <= '0;
            func3_reg   <= '0;
            func7_5_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                opcode_reg  <= opcode;
                func3_reg   <= func3;
                func7_5_reg <= func7[5];
            end
            if (retire) begin
                retired_reg <= retired_reg + RET_W'(1);
            end
        end
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_reg;

    // Counts only stalled FETCH/MEM cycles; any other cycle (incl. completion) re-arms it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_reg <= '0;
        end else if ((state_reg == FETCH || state_reg == MEM) && !mem_ready) begin
            wait_reg <= wait_reg + 1'b1;
        end else begin
            wait_reg <= '0;
        end
    end

    assign timeout = !mem_ready && (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^MEM_TIMEOUT;
    assign timeout        = 1'b0;
`endif

    ctrl_alu_dec u_alu_dec (
        .opcode  (opcode_reg),
        .func3   (func3_reg),
        .func7_5 (func7_5_reg),
        .alu_op  (dec_alu_op)
    );

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_sel    = MEM_SEL_PC;
        we         = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_sel     = PC_SEL_PC4;
        imm_type   = IMM_DEFAULT;
        alu1_sel   = ALU1_RS;
        alu2_sel   = ALU2_RS;
        alu_op     = ALU_ADD;
        rd_sel     = RD_ALU;
        reg_wr     = 1'b0;
        trap       = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr      = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = TRAP;
                end
            end
            DECODE: state_next = is_legal(opcode) ? EXEC : TRAP;
            EXEC: begin
                imm_type = imm_of(opcode_reg);
                alu1_sel = (opcode_reg == OPC_BRANCH || opcode_reg == OPC_JAL ||
                            opcode_reg == OPC_AUIPC) ? ALU1_PC : ALU1_RS;
                alu2_sel = (opcode_reg == OPC_OP) ? ALU2_RS : ALU2_IMM;
                alu_op   = dec_alu_op;
                case (opcode_reg)
                    OPC_LOAD, OPC_STORE: state_next = MEM;
                    OPC_BRANCH: begin
                        pc_wr      = 1'b1;
                        pc_sel     = b;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = WB;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_sel = MEM_SEL_ALU;
                we      = (opcode_reg == OPC_STORE);
                if (mem_ready) begin
                    if (opcode_reg == OPC_STORE) begin
                        pc_wr      = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (timeout) begin
                    state_next = TRAP;
                end
            end
            WB: begin
                reg_wr = 1'b1;
                pc_wr  = 1'b1;
                retire = 1'b1;
                case (opcode_reg)
                    OPC_LOAD:          rd_sel = RD_MEM;
                    OPC_JAL, OPC_JALR: rd_sel = RD_PC4;
                    OPC_LUI:           rd_sel = RD_IMM;
                    default:           rd_sel = RD_ALU;
                endcase
                pc_sel     = (opcode_reg == OPC_JAL || opcode_reg == OPC_JALR) ? PC_SEL_ALU : PC_SEL_PC4;
                state_next = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: per-cycle expected output vectors are queued
// alongside their stimulus and compared at the falling edge.
module tb_ctrl_seq;

    localparam logic [4:0] T_LOAD = 5'b00000, T_OPIMM = 5'b00100, T_AUIPC = 5'b00101,
                           T_STORE = 5'b01000, T_OP = 5'b01100, T_LUI = 5'b01101,
                           T_BRANCH = 5'b11000, T_JALR = 5'b11001, T_JAL = 5'b11011;
    localparam logic [2:0] I_I = ctrl_seq_pkg::IMM_I, I_S = ctrl_seq_pkg::IMM_S,
                           I_B = ctrl_seq_pkg::IMM_B, I_U = ctrl_seq_pkg::IMM_U,
                           I_J = ctrl_seq_pkg::IMM_J, I_D = ctrl_seq_pkg::IMM_DEFAULT;
    localparam logic A1_RS = ctrl_seq_pkg::ALU1_RS, A1_PC = ctrl_seq_pkg::ALU1_PC;
    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic        b = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_sel, we, ir_wr, pc_wr, pc_sel, alu1_sel, alu2_sel, reg_wr, trap;
    logic [2:0]  imm_type;
    logic [3:0]  alu_op;
    logic [1:0]  rd_sel;
    logic [31:0] retired;

    always #5 clk = ~clk;

    ctrl_seq #(.MEM_TIMEOUT(4), .RET_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel), .we(we),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel), .imm_type(imm_type),
        .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .alu_op(alu_op), .rd_sel(rd_sel),
        .reg_wr(reg_wr), .trap(trap), .retired(retired)
    );

    typedef struct packed {
        logic       rdy;
        logic       bb;
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
    } stim_t;

    stim_t       stim_q[$];
    logic [18:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_retired = 0;
    int          cyc = 0;
    logic [18:0] obs, e;
    logic [18:0] quiet;

    assign obs = {mem_req, mem_sel, we, ir_wr, pc_wr, pc_sel, imm_type, alu1_sel,
                  alu2_sel, alu_op, rd_sel, reg_wr, trap};

    function automatic logic [18:0] mk(input logic req, input logic sel, input logic wen,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic [2:0] imm, input logic a1, input logic a2,
                                       input logic [3:0] aop, input logic [1:0] rd,
                                       input logic rw, input logic tr);
        return {req, sel, wen, irw, pcw, pcs, imm, a1, a2, aop, rd, rw, tr};
    endfunction

    task automatic push(input logic rdy, input logic bb, input logic [4:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [18:0] ev);
        stim_t s;
        s = {rdy, bb, op, f3, f7};
        stim_q.push_back(s);
        exp_q.push_back(ev);
    endtask

    // Queue one whole instruction; fields after DECODE are scrambled so EXEC..WB
    // must come from the latched copy.
    task automatic push_instr(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic bb, input int fwait, input int mwait,
                              input logic [2:0] imm, input logic a1, input logic a2,
                              input logic [3:0] aop, input int kind, input logic [1:0] rd,
                              input logic wpcs);
        logic st, br;
        st = (kind == K_ST);
        br = (kind == K_BR);
        for (int i = 0; i < fwait; i++)
            push(1'b0, bb, 5'b11111, ~f3, ~f7, mk(1, 0, 0, 0, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
        push(1'b1, bb, 5'b11111, ~f3, ~f7, mk(1, 0, 0, 1, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
        push(1'b1, bb, op, f3, f7, quiet);
        push(1'b1, bb, 5'b11111, ~f3, ~f7, mk(0, 0, 0, 0, br, br & bb, imm, a1, a2, aop, 2'd0, 0, 0));
        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i < mwait; i++)
                push(1'b0, bb, 5'b11111, ~f3, ~f7, mk(1, 1, st, 0, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
            push(1'b1, bb, 5'b11111, ~f3, ~f7, mk(1, 1, st, 0, st, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
        end
        if (kind == K_ALU || kind == K_LD)
            push(1'b1, bb, 5'b11111, ~f3, ~f7, mk(0, 0, 0, 0, 1, wpcs, I_D, A1_RS, 0, 4'd0, rd, 1, 0));
        exp_retired++;
    endtask

    task automatic apply_next(output logic [18:0] ev);
        stim_t s;
        s = stim_q.pop_front();
        ev = exp_q.pop_front();
        mem_ready = s.rdy;
        b = s.bb;
        opcode = s.op;
        func3 = s.f3;
        func7 = s.f7;
        @(negedge clk);
        cyc++;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        cyc = -1;
        push(1'b1, 1'b0, 5'b11111, 3'd0, 7'd0, quiet);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (obs !== quiet || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: observed %05h/%0d required %05h/0", obs, retired, quiet);
        end
        @(posedge clk); @(posedge clk); #1;
        release_reset();
    endtask

    task automatic test_addi();
        push_instr(T_OPIMM, 3'b000, 7'd0, 0, 0, 0, I_I, A1_RS, 1, 4'd0, K_ALU, 2'd0, 0);
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL addi cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (retired !== 32'(exp_retired)) begin
            miscompares++;
            $display("FAIL addi_retired: observed %0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_alu_decode();
        push_instr(T_OP,    3'b000, 7'b0100000, 0, 0, 0, I_D, A1_RS, 0, 4'd1, K_ALU, 2'd0, 0);
        push_instr(T_OPIMM, 3'b101, 7'b0100000, 0, 0, 0, I_I, A1_RS, 1, 4'd7, K_ALU, 2'd0, 0);
        push_instr(T_OPIMM, 3'b000, 7'b0100000, 0, 0, 0, I_I, A1_RS, 1, 4'd0, K_ALU, 2'd0, 0);
        push_instr(T_OP,    3'b101, 7'b0000000, 0, 0, 0, I_D, A1_RS, 0, 4'd6, K_ALU, 2'd0, 0);
        push_instr(T_OP,    3'b111, 7'b0000000, 0, 0, 0, I_D, A1_RS, 0, 4'd9, K_ALU, 2'd0, 0);
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL alu_decode cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        push_instr(T_BRANCH, 3'b000, 7'd0, 1, 0, 0, I_B, A1_PC, 1, 4'd0, K_BR, 2'd0, 0);
        push_instr(T_BRANCH, 3'b001, 7'd0, 0, 0, 0, I_B, A1_PC, 1, 4'd0, K_BR, 2'd0, 0);
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL branch cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (retired !== 32'(exp_retired)) begin
            miscompares++;
            $display("FAIL branch_retired: observed %0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_mem();
        push_instr(T_LOAD,  3'b010, 7'd0, 0, 1, 3, I_I, A1_RS, 1, 4'd0, K_LD, 2'd1, 0);
        push_instr(T_STORE, 3'b010, 7'd0, 0, 0, 0, I_S, A1_RS, 1, 4'd0, K_ST, 2'd0, 0);
        push_instr(T_STORE, 3'b000, 7'd0, 1, 2, 2, I_S, A1_RS, 1, 4'd0, K_ST, 2'd0, 0);
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mem cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (retired !== 32'(exp_retired)) begin
            miscompares++;
            $display("FAIL mem_retired: observed %0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_back_to_back();
        push_instr(T_LUI,   3'b000, 7'd0, 0, 0, 0, I_U, A1_RS, 1, 4'd0, K_ALU, 2'd3, 0);
        push_instr(T_AUIPC, 3'b000, 7'd0, 0, 0, 0, I_U, A1_PC, 1, 4'd0, K_ALU, 2'd0, 0);
        push_instr(T_JAL,   3'b000, 7'd0, 0, 0, 0, I_J, A1_PC, 1, 4'd0, K_ALU, 2'd2, 1);
        push_instr(T_JALR,  3'b000, 7'd0, 0, 0, 0, I_I, A1_RS, 1, 4'd0, K_ALU, 2'd2, 1);
        push_instr(T_OPIMM, 3'b011, 7'd0, 0, 0, 0, I_I, A1_RS, 1, 4'd4, K_ALU, 2'd0, 0);
        push_instr(T_OP,    3'b100, 7'd0, 0, 0, 0, I_D, A1_RS, 0, 4'd5, K_ALU, 2'd0, 0);
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (retired !== 32'(exp_retired)) begin
            miscompares++;
            $display("FAIL b2b_retired: observed %0d required %0d", retired, exp_retired);
        end
    endtask

    // Reset lands in the middle of a taken branch's EXEC cycle.
    task automatic test_abort();
        push(1'b1, 1'b1, 5'b11111, 3'd0, 7'd0, mk(1, 0, 0, 1, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
        push(1'b1, 1'b1, T_BRANCH, 3'd0, 7'd0, quiet);
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_pre cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        b = 1'b1;
        #1;
        e = mk(0, 0, 0, 0, 1, 1, I_B, A1_PC, 1, 4'd0, 2'd0, 0, 0);
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL abort_exec: observed %05h required %05h", obs, e);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== quiet || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_reset: observed %05h/%0d required %05h/0", obs, retired, quiet);
        end
        exp_retired = 0;
        @(posedge clk); #1;
        vectors++;
        if (obs !== quiet || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_held: observed %05h/%0d required %05h/0", obs, retired, quiet);
        end
        release_reset();
    endtask

    task automatic test_trap();
        push_instr(T_OPIMM, 3'b000, 7'd0, 0, 0, 0, I_I, A1_RS, 1, 4'd0, K_ALU, 2'd0, 0);
        push(1'b1, 1'b0, 5'b11111, 3'd0, 7'd0, mk(1, 0, 0, 1, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
        push(1'b1, 1'b0, 5'b11111, 3'd0, 7'd0, quiet);
        for (int i = 0; i < 20; i++)
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), T_OPIMM, 3'd0, 7'd0,
                 mk(0, 0, 0, 0, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 1));
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL trap cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (retired !== 32'(exp_retired)) begin
            miscompares++;
            $display("FAIL trap_retired: observed %0d required %0d", retired, exp_retired);
        end
        rst = 1'b0;
        #2;
        vectors++;
        if (obs !== quiet || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL trap_clear: observed %05h/%0d required %05h/0", obs, retired, quiet);
        end
        exp_retired = 0;
        @(posedge clk); #1;
        release_reset();
    endtask

    task automatic test_timeout();
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            push(1'b0, 1'b0, 5'b11111, 3'd0, 7'd0, mk(1, 0, 0, 0, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0));
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b0, 5'b11111, 3'd0, 7'd0, mk(0, 0, 0, 0, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 1));
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL timeout_trap cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        release_reset();
        push_instr(T_OPIMM, 3'b000, 7'd0, 0, 3, 0, I_I, A1_RS, 1, 4'd0, K_ALU, 2'd0, 0);
`else
        push_instr(T_OPIMM, 3'b000, 7'd0, 0, 20, 0, I_I, A1_RS, 1, 4'd0, K_ALU, 2'd0, 0);
`endif
        while (exp_q.size() > 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL timeout_edge cyc%0d: observed %05h required %05h", cyc, obs, e);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (retired !== 32'(exp_retired)) begin
            miscompares++;
            $display("FAIL timeout_retired: observed %0d required %0d", retired, exp_retired);
        end
    endtask

    initial begin
        quiet = mk(0, 0, 0, 0, 0, 0, I_D, A1_RS, 0, 4'd0, 2'd0, 0, 0);
        test_reset();
        test_addi();
        test_alu_decode();
        test_branch();
        test_mem();
        test_back_to_back();
        test_abort();
        test_trap();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
